// File: rtl/pong_pkg.sv
// Shared Pong sound definitions: sound-state encoding (doubles as priority)
// and default burst lengths so game logic and the sequencer agree.
package pong_pkg;

    typedef logic [1:0] sound_t;

    localparam sound_t SND_IDLE = 2'd0;
    localparam sound_t SND_WALL = 2'd1;
    localparam sound_t SND_PAD  = 2'd2;
    localparam sound_t SND_GOAL = 2'd3;

    localparam int DEF_TICK_W         = 8;
    localparam int DEF_PAD_TICKS      = 8;
    localparam int DEF_WALL_TICKS     = 4;
    localparam int DEF_GOAL_SEG_TICKS = 10;
    localparam int DEF_GOAL_SEGS      = 4;

    // Highest-priority event wins when several edges land in the same cycle.
    function automatic sound_t event_priority(input logic goal_e,
                                              input logic pad_e,
                                              input logic wall_e);
        if (goal_e) begin
            return SND_GOAL;
        end else if (pad_e) begin
            return SND_PAD;
        end else if (wall_e) begin
            return SND_WALL;
        end
        return SND_IDLE;
    endfunction

endpackage

// File: rtl/buzzer_sequencer_if.sv
// Game-side bundle for the buzzer sequencer: tick, tones, pause, events in;
// buzzer drive and status out.
interface buzzer_sequencer_if;
    import pong_pkg::*;

    logic   pause;
    logic   game_en;
    logic   pad_tone;
    logic   wall_tone;
    logic   pad_hit;
    logic   wall_hit;
    logic   goal;
    logic   buzzer;
    logic   busy;
    sound_t sound_id;

    modport master (
        output pause, game_en, pad_tone, wall_tone, pad_hit, wall_hit, goal,
        input  buzzer, busy, sound_id
    );

    modport slave (
        input  pause, game_en, pad_tone, wall_tone, pad_hit, wall_hit, goal,
        output buzzer, busy, sound_id
    );

endinterface

// File: rtl/buzzer_sequencer_rise_detect.sv
// One-bit rising-edge detector: registered previous sample, output in & ~prev.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/buzzer_sequencer.sv
// Pong sound-effect sequencer: turns paddle/wall/goal events into timed,
// prioritised tone bursts on a single registered buzzer pin.
//
// state | meaning
// IDLE  | silent, waiting for an event edge
// WALL  | wall-hit burst, wall_tone, WALL_TICKS ticks
// PAD   | pad-hit burst, pad_tone, PAD_TICKS ticks
// GOAL  | jingle, GOAL_SEGS segments of GOAL_SEG_TICKS, tone alternates per segment
module buzzer_sequencer
    import pong_pkg::*;
#(
    parameter int TICK_W         = DEF_TICK_W,
    parameter int PAD_TICKS      = DEF_PAD_TICKS,
    parameter int WALL_TICKS     = DEF_WALL_TICKS,
    parameter int GOAL_SEG_TICKS = DEF_GOAL_SEG_TICKS,
    parameter int GOAL_SEGS      = DEF_GOAL_SEGS
) (
    input logic               clk,
    input logic               rst_n,
    buzzer_sequencer_if.slave bus
);

    localparam logic [TICK_W-1:0] PAD_LOAD  = TICK_W'(PAD_TICKS);
    localparam logic [TICK_W-1:0] WALL_LOAD = TICK_W'(WALL_TICKS);
    localparam logic [TICK_W-1:0] GOAL_LOAD = TICK_W'(GOAL_SEG_TICKS);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [3:0]        LAST_SEG  = 4'(GOAL_SEGS - 1);

    sound_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        seg_q, seg_d;
    logic              buzzer_q, buzzer_d;
    logic              armed_q;

    logic              goal_rise, pad_rise, wall_rise;
    sound_t            evt_pri;
    logic [TICK_W-1:0] entry_load;
    logic              tone;

    rise_detect u_goal_rd (.clk(clk), .rst_n(rst_n), .in_i(bus.goal),     .rise_o(goal_rise));
    rise_detect u_pad_rd  (.clk(clk), .rst_n(rst_n), .in_i(bus.pad_hit),  .rise_o(pad_rise));
    rise_detect u_wall_rd (.clk(clk), .rst_n(rst_n), .in_i(bus.wall_hit), .rise_o(wall_rise));

    // The edge registers clear on reset, so a level already high at release
    // would look like a fresh edge; ignore edges for that first cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign evt_pri = armed_q ? event_priority(goal_rise, pad_rise, wall_rise) : SND_IDLE;

    always_comb begin
        entry_load = '0;
        case (evt_pri)
            SND_WALL: entry_load = WALL_LOAD;
            SND_PAD:  entry_load = PAD_LOAD;
            SND_GOAL: entry_load = GOAL_LOAD;
            default:  entry_load = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        seg_d   = seg_q;
        if (!bus.pause) begin
            if ((evt_pri != SND_IDLE) && (evt_pri >= state_q)) begin
                state_d = evt_pri;
                tick_d  = entry_load;
                seg_d   = '0;
            end else if ((state_q != SND_IDLE) && bus.game_en) begin
                if (tick_q == TICK_ONE) begin
                    if ((state_q == SND_GOAL) && (seg_q != LAST_SEG)) begin
                        seg_d  = seg_q + 4'd1;
                        tick_d = GOAL_LOAD;
                    end else begin
                        state_d = SND_IDLE;
                        tick_d  = '0;
                        seg_d   = '0;
                    end
                end else begin
                    tick_d = tick_q - TICK_ONE;
                end
            end
        end
    end

    always_comb begin
        tone = 1'b0;
        case (state_q)
            SND_WALL: tone = bus.wall_tone;
            SND_PAD:  tone = bus.pad_tone;
            SND_GOAL: tone = seg_q[0] ? bus.wall_tone : bus.pad_tone;
            default:  tone = 1'b0;
        endcase
    end

    assign buzzer_d = tone & ~bus.pause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SND_IDLE;
            tick_q   <= '0;
            seg_q    <= '0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            seg_q    <= seg_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign bus.buzzer   = buzzer_q;
    assign bus.busy     = (state_q != SND_IDLE);
    assign bus.sound_id = state_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scenario bench for buzzer_sequencer: expected {buzzer,busy,sound_id} words
// are queued as stimulus is applied and popped when the output is sampled.
module tb_buzzer_sequencer;
    import pong_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    buzzer_sequencer_if bus ();

    buzzer_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] v;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   miss = 0;

    // Observed word: {buzzer, busy, sound_id}
    function automatic logic [3:0] obs();
        return {bus.buzzer, bus.busy, bus.sound_id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic [3:0] v);
        sb.push_back('{n, v});
    endtask

    task automatic tick();
        bus.game_en = 1'b1;
        step();
        bus.game_en = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        bus.pad_hit = 1'b1; bus.wall_hit = 1'b1; bus.goal = 1'b1;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b1;
        repeat (3) step();
        push("reset_hold", 4'b0000);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("reset_release_%0d", i), 4'b0000);
            step();
            e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        end
        bus.pad_hit = 1'b0; bus.wall_hit = 1'b0; bus.goal = 1'b0;
        bus.wall_tone = 1'b0;
        step();
        step();
    endtask

    task automatic test_pad_burst();
        exp_t e;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
        bus.pad_hit = 1'b1;
        push("pad_enter", 4'b0110);
        step();
        bus.pad_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        push("pad_tone_hi", 4'b1110);
        step();
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.pad_tone = 1'b0;
        push("pad_tone_lo", 4'b0110);
        step();
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.pad_tone = 1'b1;
        step();
        repeat (7) tick();
        push("pad_7ticks", 4'b1110);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.game_en = 1'b1;
        push("pad_end_busy", 4'b1000);
        step();
        bus.game_en = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        push("pad_end_buzz", 4'b0000);
        step();
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    endtask

    task automatic test_preempt_drop();
        exp_t e;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
        bus.wall_hit = 1'b1;
        push("wall_enter", 4'b0101);
        step();
        bus.wall_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (2) tick();
        push("wall_2ticks", 4'b0101);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.pad_hit = 1'b1;
        push("pad_preempt", 4'b0110);
        step();
        bus.pad_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (3) tick();
        bus.wall_hit = 1'b1;
        push("wall_dropped", 4'b1110);
        step();
        bus.wall_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (4) tick();
        push("preempt_7ticks", 4'b1110);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.game_en = 1'b1;
        push("preempt_end", 4'b1000);
        step();
        bus.game_en = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        step();
    endtask

    task automatic test_entry_restart();
        exp_t e;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
        bus.pad_hit = 1'b1;
        bus.game_en = 1'b1;
        push("entry_with_tick", 4'b0110);
        step();
        bus.pad_hit = 1'b0;
        bus.game_en = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        step();
        repeat (7) tick();
        push("entry_7ticks", 4'b1110);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.pad_hit = 1'b1;
        push("pad_restart", 4'b1110);
        step();
        bus.pad_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (7) tick();
        push("restart_7ticks", 4'b1110);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.game_en = 1'b1;
        push("restart_end", 4'b1000);
        step();
        bus.game_en = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        step();
    endtask

    task automatic test_simultaneous();
        exp_t e;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
        bus.goal = 1'b1; bus.pad_hit = 1'b1; bus.wall_hit = 1'b1;
        push("goal_enter", 4'b0111);
        step();
        bus.goal = 1'b0; bus.pad_hit = 1'b0; bus.wall_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        for (int s = 0; s < 4; s++) begin
            repeat (5) tick();
            push($sformatf("goal_mid_seg%0d", s), (s % 2 == 0) ? 4'b1111 : 4'b0111);
            e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
            bus.pad_tone = 1'b0; bus.wall_tone = 1'b1;
            push($sformatf("goal_swap_seg%0d", s), (s % 2 == 0) ? 4'b0111 : 4'b1111);
            step();
            e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
            bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
            step();
            repeat (4) tick();
            if (s < 3) begin
                tick();
                push($sformatf("goal_next_seg%0d", s + 1), ((s + 1) % 2 == 0) ? 4'b1111 : 4'b0111);
                e = sb.pop_front(); vecs++;
                if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
            end else begin
                bus.game_en = 1'b1;
                push("goal_end", 4'b0000);
                step();
                bus.game_en = 1'b0;
                e = sb.pop_front(); vecs++;
                if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
            end
        end
        step();
    endtask

    task automatic test_pause();
        exp_t e;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
        bus.pad_hit = 1'b1;
        push("pause_enter", 4'b0110);
        step();
        bus.pad_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (3) tick();
        bus.pause = 1'b1;
        push("pause_buzz_off", 4'b0110);
        step();
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        for (int i = 0; i < 50; i++) begin
            bus.pad_hit = ~bus.pad_hit;
            bus.goal = (i % 5 == 2);
            tick();
        end
        bus.pad_hit = 1'b0;
        bus.goal = 1'b0;
        step();
        push("pause_hold", 4'b0110);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.pause = 1'b0;
        push("pause_resume", 4'b1110);
        step();
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (4) tick();
        push("pause_4after", 4'b1110);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.game_en = 1'b1;
        push("pause_end", 4'b1000);
        step();
        bus.game_en = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        step();
    endtask

    task automatic test_reset_mid_goal();
        exp_t e;
        bus.pad_tone = 1'b1; bus.wall_tone = 1'b0;
        bus.goal = 1'b1;
        push("goal2_enter", 4'b0111);
        step();
        bus.goal = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (25) tick();
        push("goal_seg2", 4'b1111);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        rst_n = 1'b0;
        push("mid_reset", 4'b0000);
        step();
        rst_n = 1'b1;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        for (int i = 0; i < 3; i++) begin
            push($sformatf("post_reset_idle_%0d", i), 4'b0000);
            tick();
            e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        end
        bus.wall_tone = 1'b1;
        bus.wall_hit = 1'b1;
        push("wall_after_reset", 4'b0101);
        step();
        bus.wall_hit = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        repeat (3) tick();
        push("wall_3ticks", 4'b1101);
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        bus.game_en = 1'b1;
        push("wall_end", 4'b1000);
        step();
        bus.game_en = 1'b0;
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
        push("wall_end_buzz", 4'b0000);
        step();
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin miss++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    endtask

    initial begin
        bus.pause = 1'b0; bus.game_en = 1'b0;
        bus.pad_tone = 1'b0; bus.wall_tone = 1'b0;
        bus.pad_hit = 1'b0; bus.wall_hit = 1'b0; bus.goal = 1'b0;
        test_reset();
        test_pad_burst();
        test_preempt_drop();
        test_entry_restart();
        test_simultaneous();
        test_pause();
        test_reset_mid_goal();
        vecs++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
